// File: rtl/snake_dir_if.sv
// -----------------------------------------------------------------------------
// snake_dir_if
// Purpose : groups the player/game-side signals of snake_dir_ctrl into one bus.
// Signals :
//   key       [3:0]          raw push-buttons, active low, async to the clock
//   step                     one-cycle pulse, snake advances one cell
//   collide   [NUM_COLL-1:0] collision flags, any bit high restarts the game
//   direction [1:0]          applied direction (bit 1 selects the axis)
//   q_count   [3:0]          number of buffered turns
//   drop                     one-cycle pulse when an accepted press is discarded
// Modports: master drives key/step/collide, slave (the controller) drives
//           direction/q_count/drop.
// -----------------------------------------------------------------------------
interface snake_dir_if #(
    parameter int NUM_COLL = 2
);
    logic [3:0]          key;
    logic                step;
    logic [NUM_COLL-1:0] collide;
    logic [1:0]          direction;
    logic [3:0]          q_count;
    logic                drop;

    modport master (
        output key, step, collide,
        input  direction, q_count, drop
    );

    modport slave (
        input  key, step, collide,
        output direction, q_count, drop
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// snake_dir_ctrl
// Purpose : turns four debounced push-buttons into a queue of snake turns and
//           applies one queued turn per step. Same-axis presses are ignored,
//           a press into a full queue is dropped, a collision resets the
//           direction and flushes the queue.
// Ports   :
//   sys_clk    single system clock
//   sys_rst_n  asynchronous active-low reset
//   bus        snake_dir_if.slave (key, step, collide in; direction,
//              q_count, drop out)
// -----------------------------------------------------------------------------
module snake_dir_ctrl #(
    parameter int         DEB_CYCLES  = 500000,
    parameter int         QUEUE_DEPTH = 2,
    parameter int         NUM_COLL    = 2,
    parameter logic [1:0] INIT_DIR    = 2'd0
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    snake_dir_if.slave     bus
);

    localparam int                 CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEB_CYCLES - 1);
    localparam int                 PTR_W    = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam logic [PTR_W-1:0]   PTR_LAST = PTR_W'(QUEUE_DEPTH - 1);
    localparam logic [3:0]         DEPTH_Q  = 4'(QUEUE_DEPTH);

    logic [3:0]          r_sync1;
    logic [3:0]          r_key_s;
    logic [3:0]          r_deb;
    logic [3:0]          r_deb_d;
    logic [3:0]          r_press;
    logic [CNT_W-1:0]    r_cnt [4];

    logic [1:0]          r_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [3:0]          r_count;
    logic [1:0]          r_dir;
    logic                r_drop;

    logic [NUM_COLL-1:0] w_collide;
    logic                w_coll;
    logic                w_has_press;
    logic [1:0]          w_sel;
    logic [PTR_W-1:0]    w_tail_idx;
    logic [1:0]          w_ref;
    logic                w_valid;
    logic                w_full;
    logic                w_pop;
    logic                w_push;
    logic                w_drop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Synchroniser, debounce and press-event detection. Reset forces the
    // debounced level high, so a key still held at reset release needs a full
    // new stable window before it can produce an event.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_sync1 <= '1;
            r_key_s <= '1;
            r_deb   <= '1;
            r_deb_d <= '1;
            r_press <= '0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= bus.key;
            r_key_s <= r_sync1;
            r_deb_d <= r_deb;
            // Falling debounced level, seen one cycle late, is the press event.
            r_press <= r_deb_d & ~r_deb;
            for (int i = 0; i < 4; i++) begin
                if (r_key_s[i] == r_deb[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_deb[i] <= r_key_s[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_collide = bus.collide;

    // Turn arbitration: lowest-index press wins; the check is made against the
    // last queued turn (or the applied direction when nothing is queued), which
    // is always the pre-pop view even when a step pops in the same cycle.
    always_comb begin
        w_sel       = 2'd0;
        w_has_press = |r_press;
        if (r_press[0])      w_sel = 2'd0;
        else if (r_press[1]) w_sel = 2'd1;
        else if (r_press[2]) w_sel = 2'd2;
        else if (r_press[3]) w_sel = 2'd3;

        w_tail_idx = (r_wr_ptr == '0) ? PTR_LAST : r_wr_ptr - PTR_W'(1);
        w_ref      = (r_count != 4'd0) ? r_mem[w_tail_idx] : r_dir;
        w_coll     = |w_collide;
        w_valid    = w_has_press && (w_sel[1] != w_ref[1]);
        w_full     = (r_count == DEPTH_Q);
        w_pop      = !w_coll && bus.step && (r_count != 4'd0);
        // A full queue still accepts the press when a step frees a slot.
        w_push     = !w_coll && w_valid && (!w_full || w_pop);
        w_drop     = !w_coll && w_valid && w_full && !w_pop;
    end

    // Queue control and applied direction; collision beats step beats push.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_dir    <= INIT_DIR;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_drop   <= 1'b0;
        end else begin
            r_drop <= w_drop;
            if (w_coll) begin
                r_dir    <= INIT_DIR;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pop) begin
                    r_dir    <= r_mem[r_rd_ptr];
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_push) begin
                    r_wr_ptr <= ptr_inc(r_wr_ptr);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 4'd1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 4'd1;
                end
            end
        end
    end

    // Queue storage holds data only; validity is tracked by r_count.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_sel;
        end
    end

    assign bus.direction = r_dir;
    assign bus.q_count   = r_count;
    assign bus.drop      = r_drop;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
module tb_snake_dir_ctrl;

    localparam int         DEB   = 4;
    localparam int         DEPTH = 2;
    localparam int         NCOLL = 2;
    localparam logic [1:0] INIT  = 2'd0;

    logic clk;
    logic rst_n;

    snake_dir_if #(.NUM_COLL(NCOLL)) bus ();

    snake_dir_ctrl #(
        .DEB_CYCLES (DEB),
        .QUEUE_DEPTH(DEPTH),
        .NUM_COLL   (NCOLL),
        .INIT_DIR   (INIT)
    ) dut (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .bus      (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec  = 0;
    int n_err  = 0;
    int drop_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Keys: two-sample delay, then a level is accepted once it has disagreed
    // with the current debounced level for DEB consecutive cycles; a newly
    // accepted low level becomes a press one cycle later. Turns live in an SV
    // queue of directions.
    logic [3:0] m_s1, m_ks, m_deb, m_fell, m_press;
    int         m_streak [4];
    int         m_q [$];
    logic [1:0] m_dir;
    logic       m_drop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 4'hF; m_ks = 4'hF; m_deb = 4'hF; m_fell = 4'h0; m_press = 4'h0;
            for (int i = 0; i < 4; i++) m_streak[i] = 0;
            m_q.delete();
            m_dir = INIT;
            m_drop = 1'b0;
        end else begin
            int sel;
            int refd;
            int n;
            bit popped;
            bit valid;
            logic [3:0] new_fell;
            sel = -1;
            for (int i = 3; i >= 0; i--) if (m_press[i]) sel = i;
            refd  = (m_q.size() > 0) ? m_q[$] : int'(m_dir);
            valid = (sel >= 0) && ((sel / 2) != (refd / 2));
            m_drop = 1'b0;
            if (bus.collide != 0) begin
                m_dir = INIT;
                m_q.delete();
            end else begin
                n = m_q.size();
                popped = 0;
                if (bus.step && n > 0) begin
                    m_dir = 2'(m_q.pop_front());
                    popped = 1;
                end
                if (valid) begin
                    if (n < DEPTH || popped) m_q.push_back(sel);
                    else m_drop = 1'b1;
                end
            end
            m_press = m_fell;
            new_fell = 4'h0;
            for (int i = 0; i < 4; i++) begin
                if (m_ks[i] == m_deb[i]) m_streak[i] = 0;
                else begin
                    m_streak[i]++;
                    if (m_streak[i] == DEB) begin
                        m_deb[i] = m_ks[i];
                        m_streak[i] = 0;
                        new_fell[i] = ~m_ks[i];
                    end
                end
            end
            m_fell = new_fell;
            m_ks = m_s1;
            m_s1 = bus.key;
        end
    end

    // Cycle-by-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        chk("direction", 32'(bus.direction), 32'(m_dir));
        chk("q_count", 32'(bus.q_count), 32'(m_q.size()));
        chk("drop", 32'(bus.drop), 32'(m_drop));
        if (bus.drop === 1'b1) drop_cnt++;
    end

    task automatic press(input int i);
        @(negedge clk);
        bus.key[i] = 1'b0;
        repeat (8) @(negedge clk);
        bus.key[i] = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic do_step();
        @(negedge clk);
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
    endtask

    initial begin
        int d0;
        bus.key = 4'hF;
        bus.step = 1'b0;
        bus.collide = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_dir", 32'(bus.direction), 32'd0);
        chk("rst_qcnt", 32'(bus.q_count), 32'd0);
        chk("rst_drop", 32'(bus.drop), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Held key[2]: event reaches the queue exactly at edge DEB+3 = 7.
        bus.key = 4'b1011;
        @(posedge clk);                 // edge 0
        repeat (6) @(posedge clk);      // edge 6
        #1 chk("lat_e6_qcnt", 32'(bus.q_count), 32'd0);
        @(posedge clk);                 // edge 7
        #1 chk("lat_e7_qcnt", 32'(bus.q_count), 32'd1);
        chk("model_e7_qcnt", 32'(m_q.size()), 32'd1);
        repeat (3) @(posedge clk);      // edge 10
        @(negedge clk) bus.step = 1'b1;
        @(posedge clk);                 // edge 11
        #1 chk("step_dir", 32'(bus.direction), 32'd2);
        chk("step_qcnt", 32'(bus.q_count), 32'd0);
        @(negedge clk);
        bus.step = 1'b0;
        bus.key = 4'hF;
        repeat (10) @(negedge clk);

        // Collision returns to INIT_DIR.
        bus.collide = 2'b01;
        @(negedge clk);
        bus.collide = '0;
        chk("coll_dir", 32'(bus.direction), 32'd0);

        // 3-cycle glitch on key[3]: no event.
        bus.key = 4'b0111;
        repeat (3) @(negedge clk);
        bus.key = 4'hF;
        repeat (12) @(negedge clk);
        chk("glitch_qcnt", 32'(bus.q_count), 32'd0);
        chk("glitch_dir", 32'(bus.direction), 32'd0);

        // Same-axis ignore, fill, drop on full, drain.
        d0 = drop_cnt;
        press(1);
        chk("same_axis_qcnt", 32'(bus.q_count), 32'd0);
        chk("same_axis_nodrop", 32'(drop_cnt - d0), 32'd0);
        press(2);
        press(0);
        chk("fill_qcnt", 32'(bus.q_count), 32'd2);
        press(3);
        chk("full_qcnt", 32'(bus.q_count), 32'd2);
        chk("full_drop", 32'(drop_cnt - d0), 32'd1);
        do_step();
        chk("drain1_dir", 32'(bus.direction), 32'd2);
        do_step();
        chk("drain2_dir", 32'(bus.direction), 32'd0);
        chk("drain_qcnt", 32'(bus.q_count), 32'd0);

        // Push validated in the same cycle as a pop of queue {2}.
        press(2);
        chk("pp_pre_qcnt", 32'(bus.q_count), 32'd1);
        @(negedge clk);
        bus.key = 4'b1110;
        repeat (7) @(negedge clk);      // just after edge 6
        bus.step = 1'b1;
        @(posedge clk);                 // edge 7: pop and push together
        #1 chk("pp_dir", 32'(bus.direction), 32'd2);
        chk("pp_qcnt", 32'(bus.q_count), 32'd1);
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
        bus.key = 4'hF;
        repeat (10) @(negedge clk);
        do_step();
        chk("pp_tail_dir", 32'(bus.direction), 32'd0);

        // Collision coincident with step on queue {1,2}, direction 3.
        press(3);
        do_step();
        press(1);
        press(2);
        chk("cs_pre_dir", 32'(bus.direction), 32'd3);
        chk("cs_pre_qcnt", 32'(bus.q_count), 32'd2);
        d0 = drop_cnt;
        @(negedge clk);
        bus.collide = 2'b10;
        bus.step = 1'b1;
        @(negedge clk);
        bus.collide = '0;
        bus.step = 1'b0;
        chk("cs_dir", 32'(bus.direction), 32'd0);
        chk("cs_qcnt", 32'(bus.q_count), 32'd0);
        chk("cs_drop", 32'(drop_cnt - d0), 32'd0);

        // Asynchronous reset with a non-empty queue.
        press(2);
        do_step();
        press(1);
        chk("ar_pre_dir", 32'(bus.direction), 32'd2);
        chk("ar_pre_qcnt", 32'(bus.q_count), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("ar_dir", 32'(bus.direction), 32'd0);
        chk("ar_qcnt", 32'(bus.q_count), 32'd0);
        chk("ar_drop", 32'(bus.drop), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Randomised traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 5) == 0) begin
                int k;
                k = int'($urandom_range(0, 3));
                bus.key[k] = ~bus.key[k];
            end
            bus.step = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 59) == 0) bus.collide = NCOLL'($urandom_range(1, 3));
            else bus.collide = '0;
            if ($urandom_range(0, 999) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        bus.key = 4'hF;
        bus.step = 1'b0;
        bus.collide = '0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
